serial_tx: RTL and testbench

Asynchronous-serial transmitter: a UART-style, 8N1-by-default, LSB-first parallel-to-serial converter.
- Accepts one data word per valid/ready handshake.
- Emits a frame on TXD: start bit (0), DATA_W data bits, one stop bit (1).
- Sits between a byte-producing core and an off-chip line; it is the sending end of the link a shift-register receiver samples.
- Single clock domain, no internal FIFO.

---
 rtl/serial_pkg.sv | 24 ++
 rtl/serial_baud_cnt.sv | 43 ++++
 rtl/serial_tx.sv | 101 ++++++++++
 tb/tb_serial_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : serial_pkg                                                  |
// | Brief   : Shared types and line-level constants for the async serial  |
// |           transmitter and its companion receiver.                     |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
package serial_pkg;

    // Frame sequencing states, shared by transmitter and receiver.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Line levels for the idle line and the framing bits.
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_baud_cnt.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : serial_baud_cnt                                             |
// | Brief   : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and raises     |
// |           TICK on the last cycle of each serial bit period.           |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module serial_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CK,
    input  logic RB,
    input  logic CLR,
    output logic TICK
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CLKS_PER_BIT - 1);

    // A bit period shorter than two clocks leaves no room for a counter.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("serial_baud_cnt: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] r_count;

    // Period counter: restarts on an explicit clear or when a period ends.
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_count <= '0;
        end else if (CLR || TICK) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign TICK = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module  : serial_tx                                                   |
// | Brief   : UART-style LSB-first transmitter: start bit, DATA_W data    |
// |           bits, one stop bit. One word per VALID/READY handshake.     |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              CK,
    input  logic              RB,
    input  logic [DATA_W-1:0] DIN,
    input  logic              VALID,
    output logic              READY,
    output logic              TXD,
    output logic              BUSY
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [DATA_W-1:0] r_shreg;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              w_take;
    logic              w_bit_done;
    logic              w_state_chg;

    // A word is accepted only while idle; READY is decoded from state alone.
    assign w_take      = VALID && (r_state == IDLE);
    // Every state change restarts the bit period, so each level lasts a full period.
    assign w_state_chg = (w_state_next != r_state);

    serial_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .CK   (CK),
        .RB   (RB),
        .CLR  (w_state_chg),
        .TICK (w_bit_done)
    );

    // State register.
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: advance through the frame one bit period at a time.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_take)     w_state_next = START;
            START:   if (w_bit_done) w_state_next = DATA;
            DATA:    if (w_bit_done && (r_bit_idx == c_LAST_IDX)) w_state_next = STOP;
            STOP:    if (w_bit_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Shift register and bit index: load at handshake, shift out LSB-first.
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            r_shreg   <= '0;
            r_bit_idx <= '0;
        end else if (w_take) begin
            r_shreg   <= DIN;
            r_bit_idx <= '0;
        end else if ((r_state == DATA) && w_bit_done) begin
            r_shreg <= r_shreg >> 1;
            if (r_bit_idx != c_LAST_IDX) begin
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
        end
    end

    // Line level decoded from registered state, so reset forces idle-high at once.
    always_comb begin
        TXD = LINE_IDLE;
        case (r_state)
            IDLE:    TXD = LINE_IDLE;
            START:   TXD = START_BIT;
            DATA:    TXD = r_shreg[0];
            STOP:    TXD = STOP_BIT;
            default: TXD = LINE_IDLE;
        endcase
    end

    assign READY = (r_state == IDLE);
    assign BUSY  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module  : tb_serial_tx                                                |
// | Brief   : Directed self-checking bench for serial_tx, including two   |
// |           extra instances for the CLKS_PER_BIT / DATA_W sweep.        |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
module tb_serial_tx;

    localparam int c_CPB = 4;
    localparam int c_DW  = 8;
    localparam int c_FRAME = (c_DW + 2) * c_CPB;

    logic       CK;
    logic       RB;
    logic [7:0] din;
    logic       valid;
    logic       ready;
    logic       txd;
    logic       busy;

    logic [4:0] s_din   [2];
    logic       s_valid [2];
    logic       s_ready [2];
    logic       s_txd   [2];
    logic       s_busy  [2];

    int n_cmp;
    int n_fail;

    serial_tx #(.DATA_W(c_DW), .CLKS_PER_BIT(c_CPB)) dut (
        .CK(CK), .RB(RB), .DIN(din), .VALID(valid),
        .READY(ready), .TXD(txd), .BUSY(busy)
    );

    serial_tx #(.DATA_W(5), .CLKS_PER_BIT(2)) dut_c2 (
        .CK(CK), .RB(RB), .DIN(s_din[0]), .VALID(s_valid[0]),
        .READY(s_ready[0]), .TXD(s_txd[0]), .BUSY(s_busy[0])
    );

    serial_tx #(.DATA_W(5), .CLKS_PER_BIT(7)) dut_c7 (
        .CK(CK), .RB(RB), .DIN(s_din[1]), .VALID(s_valid[1]),
        .READY(s_ready[1]), .TXD(s_txd[1]), .BUSY(s_busy[1])
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Expected line level for frame bit k (0 = start, 1..dw = data, dw+1 = stop).
    function automatic logic exp_bit(input logic [7:0] d, input int dw, input int k);
        if (k == 0)       return 1'b0;
        else if (k <= dw) return d[k-1];
        else              return 1'b1;
    endfunction

    task automatic test_reset();
        RB = 1'b1; valid = 1'b1; din = 8'hFF;
        s_valid[0] = 1'b0; s_valid[1] = 1'b0; s_din[0] = '0; s_din[1] = '0;
        #2 RB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CK);
            n_cmp++;
            if ({txd, ready, busy} !== 3'b110) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d: txd/ready/busy=%b required 110", i, {txd, ready, busy});
            end
        end
        RB = 1'b1;
        @(negedge CK);
        valid = 1'b0;
        n_cmp++;
        if ({txd, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_edge: txd/busy=%b required 01", {txd, busy});
        end
        for (int i = 0; i < 200 && busy; i++) @(negedge CK);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drain: busy=%b required 0", busy);
        end
    endtask

    task automatic test_single_frame();
        @(negedge CK);
        din = 8'h55; valid = 1'b1;
        @(negedge CK);
        valid = 1'b0; din = 'x;
        for (int c = 0; c < c_FRAME; c++) begin
            if (c > 0) @(negedge CK);
            n_cmp++;
            if ({txd, busy, ready} !== {exp_bit(8'h55, c_DW, c / c_CPB), 2'b10}) begin
                n_fail++;
                $display("FAIL single_55 cyc=%0d: txd/busy/ready=%b required %b", c,
                         {txd, busy, ready}, {exp_bit(8'h55, c_DW, c / c_CPB), 2'b10});
            end
        end
        @(negedge CK);
        n_cmp++;
        if ({txd, busy, ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL single_idle: txd/busy/ready=%b required 101", {txd, busy, ready});
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CK);
        din = 8'hA3; valid = 1'b1;
        @(negedge CK);
        din = 8'h0F;
        for (int c = 0; c < c_FRAME; c++) begin
            if (c > 0) @(negedge CK);
            n_cmp++;
            if (txd !== exp_bit(8'hA3, c_DW, c / c_CPB)) begin
                n_fail++;
                $display("FAIL b2b_A3 cyc=%0d: txd=%b required %b", c, txd, exp_bit(8'hA3, c_DW, c / c_CPB));
            end
        end
        @(negedge CK);
        n_cmp++;
        if ({txd, ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_gap: txd/ready=%b required 11", {txd, ready});
        end
        @(negedge CK);
        valid = 1'b0;
        for (int c = 0; c < c_FRAME; c++) begin
            if (c > 0) @(negedge CK);
            n_cmp++;
            if (txd !== exp_bit(8'h0F, c_DW, c / c_CPB)) begin
                n_fail++;
                $display("FAIL b2b_0F cyc=%0d: txd=%b required %b", c, txd, exp_bit(8'h0F, c_DW, c / c_CPB));
            end
        end
        @(negedge CK);
        n_cmp++;
        if ({txd, ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_end: txd/ready=%b required 11", {txd, ready});
        end
    endtask

    task automatic test_hold_off();
        @(negedge CK);
        din = 8'hC3; valid = 1'b1;
        @(negedge CK);
        din = 8'h00;
        for (int c = 0; c < c_FRAME; c++) begin
            if (c > 0) @(negedge CK);
            valid = (c >= c_FRAME - 2) ? 1'b1 : c[0];
            n_cmp++;
            if ({txd, ready} !== {exp_bit(8'hC3, c_DW, c / c_CPB), 1'b0}) begin
                n_fail++;
                $display("FAIL hold_C3 cyc=%0d: txd/ready=%b required %b0", c, {txd, ready},
                         exp_bit(8'hC3, c_DW, c / c_CPB));
            end
        end
        @(negedge CK);
        n_cmp++;
        if ({txd, ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL hold_gap: txd/ready=%b required 11", {txd, ready});
        end
        @(negedge CK);
        valid = 1'b0;
        for (int c = 0; c < c_FRAME; c++) begin
            if (c > 0) @(negedge CK);
            n_cmp++;
            if ({txd, busy} !== {exp_bit(8'h00, c_DW, c / c_CPB), 1'b1}) begin
                n_fail++;
                $display("FAIL hold_00 cyc=%0d: txd/busy=%b required %b1", c, {txd, busy},
                         exp_bit(8'h00, c_DW, c / c_CPB));
            end
        end
        @(negedge CK);
    endtask

    task automatic test_reset_mid_frame();
        @(negedge CK);
        din = 8'h00; valid = 1'b1;
        @(negedge CK);
        valid = 1'b0;
        // Run into data bit 3 (frame bit 4), which is a low level for 8'h00.
        for (int c = 0; c < 4 * c_CPB + 2; c++) begin
            if (c > 0) @(negedge CK);
        end
        n_cmp++;
        if (txd !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_before: txd=%b required 0", txd);
        end
        #1 RB = 1'b0;
        #1;
        n_cmp++;
        if ({txd, ready, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL mid_async: txd/ready/busy=%b required 110", {txd, ready, busy});
        end
        @(negedge CK);
        RB = 1'b1;
        @(negedge CK);
        din = 8'h81; valid = 1'b1;
        @(negedge CK);
        valid = 1'b0;
        for (int c = 0; c < c_FRAME; c++) begin
            if (c > 0) @(negedge CK);
            n_cmp++;
            if (txd !== exp_bit(8'h81, c_DW, c / c_CPB)) begin
                n_fail++;
                $display("FAIL mid_81 cyc=%0d: txd=%b required %b", c, txd, exp_bit(8'h81, c_DW, c / c_CPB));
            end
        end
        @(negedge CK);
        n_cmp++;
        if ({txd, ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_end: txd/ready=%b required 11", {txd, ready});
        end
    endtask

    task automatic test_param_sweep();
        int         cpb;
        int         len;
        int         k;
        logic [4:0] word;
        logic [4:0] rx;
        logic       framing_ok;
        for (int i = 0; i < 2; i++) begin
            cpb  = (i == 0) ? 2 : 7;
            word = (i == 0) ? 5'h16 : 5'h0B;
            @(negedge CK);
            s_din[i] = word; s_valid[i] = 1'b1;
            @(negedge CK);
            s_valid[i] = 1'b0; s_din[i] = 'x;
            len = 0; rx = '0; framing_ok = 1'b1;
            // Receiver model: sample each bit near its middle.
            while (s_busy[i] && len < 200) begin
                k = len / cpb;
                if ((len % cpb) == cpb / 2) begin
                    if (k == 0 && s_txd[i] !== 1'b0) framing_ok = 1'b0;
                    else if (k >= 1 && k <= 5) rx[k-1] = s_txd[i];
                    else if (k == 6 && s_txd[i] !== 1'b1) framing_ok = 1'b0;
                end
                len++;
                @(negedge CK);
            end
            n_cmp++;
            if (len !== 7 * cpb) begin
                n_fail++;
                $display("FAIL sweep_len cpb=%0d: cycles=%0d required %0d", cpb, len, 7 * cpb);
            end
            n_cmp++;
            if ({framing_ok, rx} !== {1'b1, word}) begin
                n_fail++;
                $display("FAIL sweep_rx cpb=%0d: framing_ok/word=%b/%h required 1/%h", cpb, framing_ok, rx, word);
            end
            n_cmp++;
            if ({s_txd[i], s_ready[i]} !== 2'b11) begin
                n_fail++;
                $display("FAIL sweep_idle cpb=%0d: txd/ready=%b required 11", cpb, {s_txd[i], s_ready[i]});
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_hold_off();
        test_reset_mid_frame();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
